// File: rtl/at_bat_ctrl_if.sv
// Scorer push-buttons in, hit pulse and ball/strike/out count out.
// The controller takes the slave view; a scoreboard/driver takes the master view.
interface at_bat_ctrl_if;
    logic       btn_single;
    logic       btn_double;
    logic       btn_triple;
    logic       btn_homer;
    logic       btn_ball;
    logic       btn_strike;
    logic       btn_out;
    logic [3:0] hit;
    logic [1:0] balls;
    logic [1:0] strikes;
    logic [1:0] outs;
    logic       inning_end;

    modport master (
        output btn_single, btn_double, btn_triple, btn_homer,
        output btn_ball, btn_strike, btn_out,
        input  hit, balls, strikes, outs, inning_end
    );

    modport slave (
        input  btn_single, btn_double, btn_triple, btn_homer,
        input  btn_ball, btn_strike, btn_out,
        output hit, balls, strikes, outs, inning_end
    );
endinterface

// File: rtl/at_bat_ctrl.sv
// At-bat controller: conditions seven scorer buttons and keeps the
// ball/strike/out count, emitting one-hot hit pulses for the base-runner tracker.
module at_bat_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    at_bat_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button index order doubles as priority order: higher index wins.
    localparam int B_BALL   = 0;
    localparam int B_STRIKE = 1;
    localparam int B_OUT    = 2;
    localparam int B_SINGLE = 3;
    localparam int B_DOUBLE = 4;
    localparam int B_TRIPLE = 5;
    localparam int B_HOMER  = 6;

    typedef enum logic [2:0] {
        EV_NONE, EV_BALL, EV_STRIKE, EV_OUT,
        EV_SINGLE, EV_DOUBLE, EV_TRIPLE, EV_HOMER
    } ev_t;

    logic [6:0] w_btn;
    logic [6:0] w_rise;
    ev_t        w_ev;

    assign w_btn[B_BALL]   = bus.btn_ball;
    assign w_btn[B_STRIKE] = bus.btn_strike;
    assign w_btn[B_OUT]    = bus.btn_out;
    assign w_btn[B_SINGLE] = bus.btn_single;
    assign w_btn[B_DOUBLE] = bus.btn_double;
    assign w_btn[B_TRIPLE] = bus.btn_triple;
    assign w_btn[B_HOMER]  = bus.btn_homer;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_deb;
            logic             r_deb_d;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn[gi];
                    r_sync2 <= r_sync1;
                    r_deb_d <= r_deb;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            // Press edges only; a release never produces an event.
            assign w_rise[gi] = r_deb & ~r_deb_d;
        end
    endgenerate

    always_comb begin
        w_ev = EV_NONE;
        if      (w_rise[B_HOMER])  w_ev = EV_HOMER;
        else if (w_rise[B_TRIPLE]) w_ev = EV_TRIPLE;
        else if (w_rise[B_DOUBLE]) w_ev = EV_DOUBLE;
        else if (w_rise[B_SINGLE]) w_ev = EV_SINGLE;
        else if (w_rise[B_OUT])    w_ev = EV_OUT;
        else if (w_rise[B_STRIKE]) w_ev = EV_STRIKE;
        else if (w_rise[B_BALL])   w_ev = EV_BALL;
    end

    logic [1:0] r_balls, r_strikes, r_outs;
    logic [3:0] r_hit;
    logic       r_inning_end;
    logic [1:0] w_balls_next, w_strikes_next, w_outs_next;
    logic [3:0] w_hit_next;
    logic       w_inning_end_next;
    logic       w_out_made;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_balls      <= 2'd0;
            r_strikes    <= 2'd0;
            r_outs       <= 2'd0;
            r_hit        <= 4'd0;
            r_inning_end <= 1'b0;
        end else begin
            r_balls      <= w_balls_next;
            r_strikes    <= w_strikes_next;
            r_outs       <= w_outs_next;
            r_hit        <= w_hit_next;
            r_inning_end <= w_inning_end_next;
        end
    end

    always_comb begin
        w_balls_next      = r_balls;
        w_strikes_next    = r_strikes;
        w_outs_next       = r_outs;
        w_hit_next        = 4'd0;
        w_inning_end_next = 1'b0;
        w_out_made        = 1'b0;
        case (w_ev)
            EV_SINGLE, EV_DOUBLE, EV_TRIPLE, EV_HOMER: begin
                w_balls_next   = 2'd0;
                w_strikes_next = 2'd0;
                case (w_ev)
                    EV_SINGLE: w_hit_next = 4'b1000;
                    EV_DOUBLE: w_hit_next = 4'b0100;
                    EV_TRIPLE: w_hit_next = 4'b0010;
                    default:   w_hit_next = 4'b0001;
                endcase
            end
            EV_BALL: begin
                if (r_balls == 2'd3) begin
                    w_hit_next     = 4'b1000;
                    w_balls_next   = 2'd0;
                    w_strikes_next = 2'd0;
                end else begin
                    w_balls_next = r_balls + 2'd1;
                end
            end
            EV_STRIKE: begin
                if (r_strikes == 2'd2) w_out_made = 1'b1;
                else                   w_strikes_next = r_strikes + 2'd1;
            end
            EV_OUT:  w_out_made = 1'b1;
            default: ;
        endcase
        // Strikeouts and fielded outs share the out/inning bookkeeping.
        if (w_out_made) begin
            w_balls_next   = 2'd0;
            w_strikes_next = 2'd0;
            if (r_outs == 2'd2) begin
                w_outs_next       = 2'd0;
                w_inning_end_next = 1'b1;
            end else begin
                w_outs_next = r_outs + 2'd1;
            end
        end
    end

    assign bus.hit        = r_hit;
    assign bus.balls      = r_balls;
    assign bus.strikes    = r_strikes;
    assign bus.outs       = r_outs;
    assign bus.inning_end = r_inning_end;

endmodule

// File: tb/tb_at_bat_ctrl.sv
// Scoreboard bench for at_bat_ctrl with DEBOUNCE_CYCLES=4: expected count/pulse
// outcomes are queued per press and matched against every DUT output change.
module tb_at_bat_ctrl;

    localparam int D = 4;
    localparam int B_BALL = 0, B_STRIKE = 1, B_OUT = 2, B_SINGLE = 3;
    localparam int B_DOUBLE = 4, B_TRIPLE = 5, B_HOMER = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] btn = 7'd0;

    at_bat_ctrl_if bus_if ();

    assign bus_if.btn_ball   = btn[B_BALL];
    assign bus_if.btn_strike = btn[B_STRIKE];
    assign bus_if.btn_out    = btn[B_OUT];
    assign bus_if.btn_single = btn[B_SINGLE];
    assign bus_if.btn_double = btn[B_DOUBLE];
    assign bus_if.btn_triple = btn[B_TRIPLE];
    assign bus_if.btn_homer  = btn[B_HOMER];

    at_bat_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed observation: {hit, inning_end, balls, strikes, outs}
    logic [10:0] exp_q[$];
    int m_balls = 0, m_strikes = 0, m_outs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_out(inout logic ie);
        m_balls = 0;
        m_strikes = 0;
        if (m_outs == 2) begin
            m_outs = 0;
            ie = 1'b1;
        end else begin
            m_outs++;
        end
    endtask

    task automatic model_event(input int idx);
        logic [3:0] hit;
        logic       ie;
        hit = 4'd0;
        ie  = 1'b0;
        case (idx)
            B_SINGLE: hit = 4'b1000;
            B_DOUBLE: hit = 4'b0100;
            B_TRIPLE: hit = 4'b0010;
            B_HOMER:  hit = 4'b0001;
            B_BALL: begin
                if (m_balls == 3) begin
                    hit = 4'b1000;
                    m_balls = 0;
                    m_strikes = 0;
                end else begin
                    m_balls++;
                end
            end
            B_STRIKE: begin
                if (m_strikes == 2) model_out(ie);
                else                m_strikes++;
            end
            default: model_out(ie);
        endcase
        if (hit != 4'd0) begin
            m_balls = 0;
            m_strikes = 0;
        end
        exp_q.push_back({hit, ie, m_balls[1:0], m_strikes[1:0], m_outs[1:0]});
        $display("press btn%0d -> expect hit=%b end=%b b=%0d s=%0d o=%0d",
                 idx, hit, ie, m_balls, m_strikes, m_outs);
    endtask

    // Monitor: any pulse or count change is a DUT output transaction.
    initial begin
        logic [10:0] cur;
        logic [5:0]  prev_cnt;
        logic [10:0] exp;
        prev_cnt = 6'd0;
        forever begin
            @(negedge clk);
            cur = {bus_if.hit, bus_if.inning_end, bus_if.balls, bus_if.strikes, bus_if.outs};
            if (reset_n && (cur[10:7] != 4'd0 || cur[6] || cur[5:0] != prev_cnt)) begin
                if (exp_q.size() == 0) begin
                    $display("unexpected output hit=%b end=%b cnt=%h", cur[10:7], cur[6], cur[5:0]);
                    chk("unexpected_evt_queue", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp = exp_q.pop_front();
                    chk("evt", 32'(cur), 32'(exp));
                end
            end
            prev_cnt = cur[5:0];
        end
    end

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic press(input int idx);
        model_event(idx);
        btn[idx] = 1'b1;
        repeat (10) @(negedge clk);
        btn[idx] = 1'b0;
        repeat (10) @(negedge clk);
        wait_drain("drain_press");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: double held through reset release
        btn[B_DOUBLE] = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hit", 32'(bus_if.hit), 32'd0);
        chk("rst_cnt", 32'({bus_if.balls, bus_if.strikes, bus_if.outs, bus_if.inning_end}), 32'd0);
        model_event(B_DOUBLE);
        reset_n = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1 chk("t1_hit_edge6", 32'(bus_if.hit), 32'd0);
        @(posedge clk);
        #1 chk("t1_hit_edge7", 32'(bus_if.hit), 32'b0100);
        @(posedge clk);
        #1 chk("t1_hit_edge8", 32'(bus_if.hit), 32'd0);
        repeat (100) @(negedge clk);
        btn[B_DOUBLE] = 1'b0;
        repeat (10) @(negedge clk);
        wait_drain("t1_drain");

        // 2: short glitch ignored, then a clean single
        btn[B_SINGLE] = 1'b1;
        repeat (3) @(negedge clk);
        btn[B_SINGLE] = 1'b0;
        repeat (15) @(negedge clk);
        press(B_SINGLE);

        // 3: four balls -> walk
        for (int i = 0; i < 4; i++) begin
            press(B_BALL);
            chk("t3_balls", 32'(bus_if.balls), 32'(m_balls));
        end
        chk("t3_strikes", 32'(bus_if.strikes), 32'd0);

        // 4: 2 balls + 3 strikes, three times -> inning end
        for (int k = 0; k < 3; k++) begin
            repeat (2) press(B_BALL);
            repeat (3) press(B_STRIKE);
            chk("t4_outs", 32'(bus_if.outs), 32'((k + 1) % 3));
            chk("t4_balls", 32'(bus_if.balls), 32'd0);
        end

        // 5: homer and ball debounce together -> homer only
        model_event(B_HOMER);
        btn[B_HOMER] = 1'b1;
        btn[B_BALL]  = 1'b1;
        repeat (10) @(negedge clk);
        btn[B_HOMER] = 1'b0;
        btn[B_BALL]  = 1'b0;
        repeat (10) @(negedge clk);
        wait_drain("t5_drain");
        chk("t5_balls", 32'(bus_if.balls), 32'd0);

        // 6: async reset mid-count and mid-debounce
        press(B_OUT);
        press(B_OUT);
        press(B_STRIKE);
        chk("t6_pre_outs", 32'(bus_if.outs), 32'd2);
        chk("t6_pre_strikes", 32'(bus_if.strikes), 32'd1);
        btn[B_OUT] = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("t6_async_cnt", 32'({bus_if.balls, bus_if.strikes, bus_if.outs}), 32'd0);
        chk("t6_async_pulse", 32'({bus_if.hit, bus_if.inning_end}), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        m_balls = 0;
        m_strikes = 0;
        m_outs = 0;
        model_event(B_OUT);
        reset_n = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1 chk("t6_outs_edge6", 32'(bus_if.outs), 32'd0);
        @(posedge clk);
        #1 chk("t6_outs_edge7", 32'(bus_if.outs), 32'd1);
        repeat (20) @(negedge clk);
        btn[B_OUT] = 1'b0;
        repeat (10) @(negedge clk);
        wait_drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
